// File: rtl/data_cache.sv
// Write-back, write-allocate, 4-way set-associative L1 data cache.
// 16 sets x 4 ways x 16 words of 64 bits. Cacheable hits answer in the
// same cycle. Misses refill through the cache bus, first writing back a
// dirty victim. Accesses with addr[31]==0 bypass the arrays as single beats.

package data_cache_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // len is the number of beats in the transfer (1 or 16); size is log2(bytes).
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [4:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module data_cache
  import data_cache_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int NUM_SETS   = 16;
  localparam int NUM_WAYS   = 4;
  localparam int LINE_WORDS = 16;
  localparam int IDX_W      = 4;
  localparam int WAY_W      = 2;
  localparam int OFF_W      = 4;
  localparam int TAG_W      = 53;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UNCACHED} state_t;

  state_t                  state_reg;
  logic [OFF_W-1:0]        beat_reg;
  logic [WAY_W-1:0]        victim_reg;
  cbus_req_t               creq_reg;
  logic [NUM_WAYS-1:0]     valid_reg [NUM_SETS];
  logic [NUM_WAYS-1:0]     dirty_reg [NUM_SETS];
  logic [WAY_W-1:0]        rr_reg    [NUM_SETS];

  // Arrays carry no reset; the valid bits alone decide what is live.
  logic [TAG_W-1:0]        tag_mem  [NUM_SETS*NUM_WAYS];
  logic [63:0]             data_mem [NUM_SETS*NUM_WAYS*LINE_WORDS];

  // The requester holds dreq stable, so its address fields address the
  // arrays for the whole life of a miss.
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] tag;
  logic             cacheable;
  assign idx       = dreq.addr[10:7];
  assign off       = dreq.addr[6:3];
  assign tag       = dreq.addr[63:11];
  assign cacheable = dreq.addr[31];

  logic [NUM_WAYS-1:0] way_hit;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim;
  logic [63:0]         hit_word;
  logic [63:0]         merged;
  logic                lookup;
  logic                hit_fire;
  logic                hit_write;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_tag_cmp
      assign way_hit[gi] = valid_reg[idx][gi] &&
                           (tag_mem[{idx, WAY_W'(gi)}] == tag);
    end
    for (gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[8*gi +: 8] = dreq.strobe[gi] ? dreq.data[8*gi +: 8]
                                                 : hit_word[8*gi +: 8];
    end
  endgenerate

  assign hit       = |way_hit;
  assign hit_word  = data_mem[{idx, hit_way, off}];
  assign lookup    = (state_reg == IDLE) && dreq.valid && cacheable;
  assign hit_fire  = lookup && hit;
  assign hit_write = hit_fire && (|dreq.strobe);

  // Encode the matching way and choose a victim (first invalid, else round-robin).
  always_comb begin
    logic found;
    hit_way = '0;
    victim  = rr_reg[idx];
    found   = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
      if (!found && !valid_reg[idx][w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  // CPU response: same-cycle hit, or the single uncached beat completing.
  always_comb begin
    dresp = '0;
    if (hit_fire) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = (|dreq.strobe) ? 64'd0 : hit_word;
    end else if (state_reg == UNCACHED && cresp.ready && cresp.last) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = cresp.data;
    end
  end

  assign creq = creq_reg;

  function automatic cbus_req_t fetch_req(input logic [63:0] a);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = 1'b0;
    r.size     = 3'd3;
    r.addr     = {a[63:7], 7'd0};
    r.len      = 5'd16;
    r.burst    = BURST_INCR;
    return r;
  endfunction

  function automatic cbus_req_t wb_req(input logic [63:0] base, input logic [63:0] first);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = 1'b1;
    r.size     = 3'd3;
    r.addr     = base;
    r.strobe   = 8'hFF;
    r.data     = first;
    r.len      = 5'd16;
    r.burst    = BURST_INCR;
    return r;
  endfunction

  function automatic cbus_req_t single_req(input dbus_req_t d);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = |d.strobe;
    r.size     = d.size;
    r.addr     = d.addr;
    r.strobe   = d.strobe;
    r.data     = d.data;
    r.len      = 5'd1;
    r.burst    = BURST_FIXED;
    return r;
  endfunction

  // Control FSM: state, line status bits, replacement pointers and the bus request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      victim_reg <= '0;
      creq_reg   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        rr_reg[s]    <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (lookup) begin
            if (hit) begin
              if (|dreq.strobe) dirty_reg[idx][hit_way] <= 1'b1;
            end else begin
              victim_reg <= victim;
              beat_reg   <= '0;
              if (valid_reg[idx][victim] && dirty_reg[idx][victim]) begin
                state_reg <= WRITEBACK;
                creq_reg  <= wb_req({tag_mem[{idx, victim}], idx, 7'd0},
                                    data_mem[{idx, victim, 4'd0}]);
              end else begin
                state_reg              <= FETCH;
                valid_reg[idx][victim] <= 1'b0;
                creq_reg               <= fetch_req(dreq.addr);
              end
            end
          end else if (dreq.valid && !cacheable) begin
            state_reg <= UNCACHED;
            creq_reg  <= single_req(dreq);
          end
        end
        WRITEBACK: begin
          if (cresp.ready) begin
            beat_reg      <= beat_reg + 4'd1;
            creq_reg.data <= data_mem[{idx, victim_reg, beat_reg + 4'd1}];
            if (cresp.last) begin
              state_reg                  <= FETCH;
              beat_reg                   <= '0;
              valid_reg[idx][victim_reg] <= 1'b0;
              dirty_reg[idx][victim_reg] <= 1'b0;
              creq_reg                   <= fetch_req(dreq.addr);
            end
          end
        end
        FETCH: begin
          if (cresp.ready) begin
            beat_reg <= beat_reg + 4'd1;
            if (cresp.last) begin
              state_reg                  <= IDLE;
              valid_reg[idx][victim_reg] <= 1'b1;
              dirty_reg[idx][victim_reg] <= 1'b0;
              rr_reg[idx]                <= rr_reg[idx] + 1'b1;
              creq_reg                   <= '0;
            end
          end
        end
        UNCACHED: begin
          if (cresp.ready && cresp.last) begin
            state_reg <= IDLE;
            creq_reg  <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Array writes: store hits merge bytes, refill beats land word by word.
  always_ff @(posedge clk) begin
    if (hit_write)
      data_mem[{idx, hit_way, off}] <= merged;
    if (state_reg == FETCH && cresp.ready)
      data_mem[{idx, victim_reg, beat_reg}] <= cresp.data;
    if (state_reg == FETCH && cresp.ready && cresp.last)
      tag_mem[{idx, victim_reg}] <= tag;
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: the CPU driver queues the expected
// response data, the bus model queues expected cache-bus beats, and two
// monitors pop and compare whenever the DUT presents a response or a beat.
module tb_data_cache;
  import data_cache_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  always #5 clk = ~clk;

  data_cache dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp),
    .creq  (creq),
    .cresp (cresp)
  );

  typedef struct {
    logic        is_write;
    logic [63:0] addr;
    logic [4:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } beat_t;

  beat_t       bq[$];
  logic [63:0] dq[$];
  logic [63:0] bmem [logic [63:0]];
  int          errors = 0;
  int          checks = 0;
  int          bus_beat = 0;
  int          beats_acc = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Memory background contents: high half is the inverted low address half.
  function automatic logic [63:0] pat(input logic [63:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return bmem.exists(a) ? bmem[a] : pat(a);
  endfunction

  function automatic logic [63:0] beat_addr();
    logic [63:0] a;
    a = (creq.burst == BURST_INCR) ? creq.addr + 64'(8 * bus_beat) : creq.addr;
    return {a[63:3], 3'b000};
  endfunction

  task automatic exp_beat(input logic we, input logic [63:0] a, input logic [4:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [7:0] strb, input logic [63:0] d);
    beat_t b;
    b.is_write = we; b.addr = a; b.len = len; b.burst = burst;
    b.size = size; b.strobe = strb; b.data = d;
    bq.push_back(b);
  endtask

  task automatic exp_fetch(input logic [63:0] base);
    for (int w = 0; w < 16; w++) exp_beat(1'b0, base, 5'd16, BURST_INCR, 3'd3, 8'h00, 64'd0);
  endtask

  // Bus slave: answer every presented beat immediately.
  initial begin
    cresp = '0;
    forever begin
      @(posedge clk); #1;
      if (creq.valid) begin
        cresp.ready = 1'b1;
        cresp.data  = mem_rd(beat_addr());
        cresp.last  = (bus_beat == int'(creq.len) - 1);
      end else begin
        cresp = '0;
      end
    end
  end

  // Bus monitor: each beat about to be accepted is compared with the queue head.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset && creq.valid && cresp.ready) begin
        if (bq.size() == 0) begin
          chk("bus_unexpected_beat", creq.addr, 64'd0);
        end else begin
          e = bq.pop_front();
          chk("bus_is_write", 64'(creq.is_write), 64'(e.is_write));
          chk("bus_addr", creq.addr, e.addr);
          chk("bus_len", 64'(creq.len), 64'(e.len));
          chk("bus_burst", 64'(creq.burst), 64'(e.burst));
          chk("bus_size", 64'(creq.size), 64'(e.size));
          if (e.is_write) begin
            chk("bus_strobe", 64'(creq.strobe), 64'(e.strobe));
            chk("bus_wdata", creq.data, e.data);
          end
        end
        if (creq.is_write) bmem[beat_addr()] = creq.data;
        beats_acc++;
        bus_beat = cresp.last ? 0 : bus_beat + 1;
      end
    end
  end

  // Response monitor: every handshake pops one expected data word.
  initial begin
    forever begin
      @(negedge clk);
      if (dresp.data_ok || dresp.addr_ok) begin
        chk("addr_ok", 64'(dresp.addr_ok), 64'd1);
        chk("data_ok", 64'(dresp.data_ok), 64'd1);
        if (dq.size() == 0) chk("dresp_unexpected", dresp.data, 64'd0);
        else chk("dresp_data", dresp.data, dq.pop_front());
      end
    end
  end

  task automatic cpu(input logic [63:0] a, input logic [2:0] size, input logic [7:0] strb,
                     input logic [63:0] wdata, input logic [63:0] exp, input bit exp_hit);
    int n;
    dq.push_back(exp);
    @(posedge clk); #1;
    dreq.valid = 1'b1; dreq.addr = a; dreq.size = size;
    dreq.strobe = strb; dreq.data = wdata;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!dresp.data_ok && n < 500);
    chk("resp_timeout", 64'(dresp.data_ok), 64'd1);
    if (exp_hit) chk("hit_latency", 64'(n), 64'd1);
    else chk("miss_latency_gt1", 64'(n > 1), 64'd1);
    $display("txn addr=%h strobe=%h cycles=%0d data=%h", a, strb, n, dresp.data);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int start;
    dreq = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_creq_valid", 64'(creq.valid), 64'd0);
    chk("rst_dresp", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    chk("rst_dresp_data", dresp.data, 64'd0);
    @(negedge clk); reset = 1'b0;

    // Cold read, then same-line hits, byte-merged write and read-back.
    exp_fetch(64'h8000_0000);
    cpu(64'h8000_0000, 3'd3, 8'h00, 64'd0, 64'h7FFF_FFFF_8000_0000, 1'b0);
    cpu(64'h8000_0008, 3'd3, 8'h00, 64'd0, 64'h7FFF_FFF7_8000_0008, 1'b1);
    cpu(64'h8000_0010, 3'd3, 8'h0F, 64'hDEAD_BEEF_1234_5678, 64'd0, 1'b1);
    cpu(64'h8000_0010, 3'd3, 8'h00, 64'd0, 64'h7FFF_FFEF_1234_5678, 1'b1);

    // Fill the rest of set 0; 0x8000_1000 is an instruction-side style read.
    exp_fetch(64'h8000_0800);
    cpu(64'h8000_0800, 3'd3, 8'h00, 64'd0, 64'h7FFF_F7FF_8000_0800, 1'b0);
    exp_fetch(64'h8000_1000);
    cpu(64'h8000_1000, 3'd3, 8'h00, 64'd0, 64'h7FFF_EFFF_8000_1000, 1'b0);
    exp_fetch(64'h8000_1800);
    cpu(64'h8000_1800, 3'd3, 8'h00, 64'd0, 64'h7FFF_E7FF_8000_1800, 1'b0);

    // Fifth line in set 0 evicts dirty way 0: writeback then fetch.
    for (int w = 0; w < 16; w++)
      exp_beat(1'b1, 64'h8000_0000, 5'd16, BURST_INCR, 3'd3, 8'hFF,
               (w == 2) ? 64'h7FFF_FFEF_1234_5678 : pat(64'h8000_0000 + 64'(8 * w)));
    exp_fetch(64'h8000_2000);
    cpu(64'h8000_2000, 3'd3, 8'h00, 64'd0, 64'h7FFF_DFFF_8000_2000, 1'b0);

    // Evicted line comes back from memory with the written-back bytes.
    exp_fetch(64'h8000_0000);
    cpu(64'h8000_0010, 3'd3, 8'h00, 64'd0, 64'h7FFF_FFEF_1234_5678, 1'b0);
    cpu(64'h8000_2008, 3'd3, 8'h00, 64'd0, 64'h7FFF_DFF7_8000_2008, 1'b1);

    // Uncached accesses: single FIXED beats, never allocated.
    exp_beat(1'b0, 64'h4000_0000, 5'd1, BURST_FIXED, 3'd2, 8'h00, 64'd0);
    cpu(64'h4000_0000, 3'd2, 8'h00, 64'd0, 64'hBFFF_FFFF_4000_0000, 1'b0);
    exp_beat(1'b0, 64'h4000_0000, 5'd1, BURST_FIXED, 3'd2, 8'h00, 64'd0);
    cpu(64'h4000_0000, 3'd2, 8'h00, 64'd0, 64'hBFFF_FFFF_4000_0000, 1'b0);
    exp_beat(1'b1, 64'h4000_0008, 5'd1, BURST_FIXED, 3'd2, 8'h0F, 64'h0000_0000_1122_3344);
    cpu(64'h4000_0008, 3'd2, 8'h0F, 64'h0000_0000_1122_3344, 64'hBFFF_FFF7_4000_0008, 1'b0);

    // Reset while FETCH presents beat 7: the transfer aborts at once.
    for (int w = 0; w < 7; w++) exp_beat(1'b0, 64'h8000_3000, 5'd16, BURST_INCR, 3'd3, 8'h00, 64'd0);
    start = beats_acc;
    @(posedge clk); #1;
    dreq.valid = 1'b1; dreq.addr = 64'h8000_3000; dreq.size = 3'd3;
    dreq.strobe = 8'h00; dreq.data = 64'd0;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (beats_acc - start < 7 && n < 200);
    chk("fetch_beats_before_reset", 64'(beats_acc - start), 64'd7);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("abort_creq_valid", 64'(creq.valid), 64'd0);
    chk("abort_dresp", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    dreq.valid = 1'b0;
    bus_beat = 0;
    $display("txn reset during fetch beat %0d", beats_acc - start);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Every line was invalidated: a previously resident word misses again.
    exp_fetch(64'h8000_0000);
    cpu(64'h8000_0008, 3'd3, 8'h00, 64'd0, 64'h7FFF_FFF7_8000_0008, 1'b0);

    repeat (4) @(posedge clk);
    chk("bus_queue_drained", 64'(bq.size()), 64'd0);
    chk("resp_queue_drained", 64'(dq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
